// File: rtl/pulse_to_level_if.sv
// Request/level bundle between a pulse producer and the pulse_to_level stretcher.
interface pulse_to_level_if #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
);
  logic              pulse_in;
  logic [CNT_W-1:0]  hold_cycles;
  logic              mode;
  logic              ack_in;
  logic              retrigger_en;
  logic              overflow_clr;
  logic              level_out;
  logic              busy;
  logic              done_pulse;
  logic [PEND_W-1:0] pending_count;
  logic              overflow;

  // Requester side: issues pulses and configuration, observes the level.
  modport master (
    output pulse_in, hold_cycles, mode, ack_in, retrigger_en, overflow_clr,
    input  level_out, busy, done_pulse, pending_count, overflow
  );

  // Stretcher side: consumes requests, produces the held level and status.
  modport slave (
    input  pulse_in, hold_cycles, mode, ack_in, retrigger_en, overflow_clr,
    output level_out, busy, done_pulse, pending_count, overflow
  );
endinterface

// File: rtl/pulse_to_level.sv
// Stretches single-cycle request pulses into held levels, either for a fixed
// cycle count or until acknowledged, queueing overlapping requests and always
// inserting a low gap between consecutive levels.
module pulse_to_level #(
  parameter int CNT_W      = 8,
  parameter int PEND_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  pulse_to_level_if.slave  bus
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic              mode_q, mode_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              level_q, level_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  holdLoad;
  logic              pendInc;
  logic              pendDec;

  assign holdLoad = (bus.hold_cycles == '0) ? CNT_W'(1) : bus.hold_cycles;

  // Next-state, counter and pending-queue logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    mode_d  = mode_q;
    pendInc = 1'b0;
    pendDec = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.pulse_in) begin
          state_d = HOLD;
          hcnt_d  = holdLoad;
          mode_d  = bus.mode;
        end
      end
      HOLD: begin
        if (!mode_q) begin
          if (bus.retrigger_en && bus.pulse_in) begin
            hcnt_d = holdLoad;
          end else begin
            pendInc = bus.pulse_in;
            if (hcnt_q == CNT_W'(1)) begin
              state_d = GAP;
              gcnt_d  = GAP_LOAD;
            end else begin
              hcnt_d = hcnt_q - CNT_W'(1);
            end
          end
        end else begin
          pendInc = bus.pulse_in;
          if (bus.ack_in) begin
            state_d = GAP;
            gcnt_d  = GAP_LOAD;
          end
        end
      end
      GAP: begin
        pendInc = bus.pulse_in;
        if (gcnt_q == GAP_W'(1)) begin
          if ((pend_q != '0) || bus.pulse_in) begin
            state_d = HOLD;
            hcnt_d  = holdLoad;
            mode_d  = bus.mode;
            pendDec = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pend_d = pend_q;
    ovf_d  = ovf_q & ~bus.overflow_clr;
    if (pendInc && !pendDec) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (pendDec && !pendInc) begin
      pend_d = pend_q - PEND_W'(1);
    end

    level_d = (state_d == HOLD);
    done_d  = (state_q == HOLD) && (state_d == GAP);
    busy_d  = (state_d != IDLE) || (pend_d != '0);
  end

  // State and output registers; reset drops the level and discards the queue without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      gcnt_q  <= '0;
      mode_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      gcnt_q  <= gcnt_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.level_out     = level_q;
  assign bus.done_pulse    = done_q;
  assign bus.busy          = busy_q;
  assign bus.pending_count = pend_q;
  assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// Scenario-driven bench for pulse_to_level: each task drives a timeline of
// requests, queues the expected output vector for the following cycle and
// compares it against the DUT one edge later.
module tb_pulse_to_level;

  logic clk;
  logic reset;

  pulse_to_level_if #(.CNT_W(8), .PEND_W(4)) bus1 ();
  pulse_to_level_if #(.CNT_W(8), .PEND_W(2)) bus2 ();

  pulse_to_level #(.CNT_W(8), .PEND_W(4), .GAP_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  pulse_to_level #(.CNT_W(8), .PEND_W(2), .GAP_CYCLES(1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // Expected output vector {level, done, busy, pending[3:0], overflow}.
  typedef struct {
    logic [7:0] vec;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiet all inputs and pulse reset for one edge; afterwards we are in cycle 0.
  task automatic applyStimulus_reset();
    bus1.pulse_in = 0; bus1.hold_cycles = 0; bus1.mode = 0; bus1.ack_in = 0;
    bus1.retrigger_en = 0; bus1.overflow_clr = 0;
    bus2.pulse_in = 0; bus2.hold_cycles = 0; bus2.mode = 0; bus2.ack_in = 0;
    bus2.retrigger_en = 0; bus2.overflow_clr = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [7:0] obs;
    applyStimulus_reset();
    reset = 1'b1;
    bus1.pulse_in = 1; bus1.hold_cycles = 8'd9; bus1.overflow_clr = 1;
    bus2.pulse_in = 1; bus2.hold_cycles = 8'd9;
    for (int c = 0; c < 3; c++) begin
      e.vec = 8'h00; e.cyc = c + 1; sbq.push_back(e);
      e.vec = 8'h00; e.cyc = c + 1; sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      obs = {bus1.level_out, bus1.done_pulse, bus1.busy, bus1.pending_count, bus1.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL reset_dut1 cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
      e = sbq.pop_front();
      obs = {2'b00, bus2.level_out, bus2.done_pulse, bus2.busy, bus2.pending_count, bus2.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL reset_dut2 cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_fixed();
    exp_t e;
    logic [7:0] obs;
    int k;
    applyStimulus_reset();
    bus1.hold_cycles = 8'd5;
    for (int c = 0; c < 20; c++) begin
      k = c + 1;
      bus1.pulse_in = (c == 10);
      e.vec = {(k >= 11 && k <= 15), (k == 16), (k >= 11 && k <= 16), 4'd0, 1'b0};
      e.cyc = k; sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      obs = {bus1.level_out, bus1.done_pulse, bus1.busy, bus1.pending_count, bus1.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL fixed cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_zero_hold();
    exp_t e;
    logic [7:0] obs;
    int k;
    applyStimulus_reset();
    bus1.hold_cycles = 8'd0;
    for (int c = 0; c < 16; c++) begin
      k = c + 1;
      bus1.pulse_in = (c == 10);
      e.vec = {(k == 11), (k == 12), (k >= 11 && k <= 12), 4'd0, 1'b0};
      e.cyc = k; sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      obs = {bus1.level_out, bus1.done_pulse, bus1.busy, bus1.pending_count, bus1.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL zero_hold cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_ack();
    exp_t e;
    logic [7:0] obs;
    int k;
    applyStimulus_reset();
    bus1.mode = 1'b1;
    bus1.hold_cycles = 8'd3;
    for (int c = 0; c < 25; c++) begin
      k = c + 1;
      bus1.pulse_in = (c == 10);
      bus1.ack_in   = (c == 5) || (c == 20);
      e.vec = {(k >= 11 && k <= 20), (k == 21), (k >= 11 && k <= 21), 4'd0, 1'b0};
      e.cyc = k; sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      obs = {bus1.level_out, bus1.done_pulse, bus1.busy, bus1.pending_count, bus1.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL ack cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
    end
    bus1.ack_in = 1'b0;
    bus1.mode   = 1'b0;
  endtask

  task automatic test_queue();
    exp_t e;
    logic [7:0] obs;
    logic [3:0] p;
    int k;
    applyStimulus_reset();
    bus1.hold_cycles = 8'd4;
    for (int c = 0; c < 30; c++) begin
      k = c + 1;
      bus1.pulse_in = (c == 10) || (c == 12) || (c == 13);
      if (k == 13)                 p = 4'd1;
      else if (k == 14 || k == 15) p = 4'd2;
      else if (k >= 16 && k <= 20) p = 4'd1;
      else                         p = 4'd0;
      e.vec = {((k >= 11 && k <= 14) || (k >= 16 && k <= 19) || (k >= 21 && k <= 24)),
               ((k == 15) || (k == 20) || (k == 25)),
               (k >= 11 && k <= 25), p, 1'b0};
      e.cyc = k; sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      obs = {bus1.level_out, bus1.done_pulse, bus1.busy, bus1.pending_count, bus1.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL queue cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_retrigger();
    exp_t e;
    logic [7:0] obs;
    int k;
    applyStimulus_reset();
    bus1.hold_cycles  = 8'd4;
    bus1.retrigger_en = 1'b1;
    for (int c = 0; c < 22; c++) begin
      k = c + 1;
      bus1.pulse_in = (c == 10) || (c == 13);
      e.vec = {(k >= 11 && k <= 17), (k == 18), (k >= 11 && k <= 18), 4'd0, 1'b0};
      e.cyc = k; sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      obs = {bus1.level_out, bus1.done_pulse, bus1.busy, bus1.pending_count, bus1.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL retrigger cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
    end
    bus1.retrigger_en = 1'b0;
  endtask

  // A pulse landing on the last gap edge with nothing pending starts the next level directly.
  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] obs;
    int k;
    applyStimulus_reset();
    bus1.hold_cycles = 8'd2;
    for (int c = 0; c < 20; c++) begin
      k = c + 1;
      bus1.pulse_in = (c == 10) || (c == 13);
      e.vec = {((k >= 11 && k <= 12) || (k >= 14 && k <= 15)), ((k == 13) || (k == 16)),
               (k >= 11 && k <= 16), 4'd0, 1'b0};
      e.cyc = k; sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      obs = {bus1.level_out, bus1.done_pulse, bus1.busy, bus1.pending_count, bus1.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
    end
  endtask

  // Small pending counter: saturation, sticky overflow, clear, set-wins, and reset mid-hold.
  task automatic test_overflow();
    exp_t e;
    logic [7:0] obs;
    logic [1:0] p;
    int k;
    applyStimulus_reset();
    bus2.hold_cycles = 8'd20;
    for (int c = 0; c < 26; c++) begin
      k = c + 1;
      bus2.pulse_in     = (c == 10) || (c >= 12 && c <= 16) || (c == 20);
      bus2.overflow_clr = (c == 18) || (c == 20);
      reset             = (c == 22);
      if (k == 13)                 p = 2'd1;
      else if (k == 14)            p = 2'd2;
      else if (k >= 15 && k <= 22) p = 2'd3;
      else                         p = 2'd0;
      e.vec = {2'b00, (k >= 11 && k <= 22), 1'b0, (k >= 11 && k <= 22), p,
               ((k >= 16 && k <= 18) || (k >= 21 && k <= 22))};
      e.cyc = k; sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      obs = {2'b00, bus2.level_out, bus2.done_pulse, bus2.busy, bus2.pending_count, bus2.overflow};
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL overflow cyc=%0d got=%b exp=%b", e.cyc, obs, e.vec);
      end
    end
    reset = 1'b0;
    bus2.pulse_in     = 1'b0;
    bus2.overflow_clr = 1'b0;
  endtask

  // Run every scenario in sequence, then report the totals.
  initial begin
    reset = 1'b1;
    test_reset();
    test_fixed();
    test_zero_hold();
    test_ack();
    test_queue();
    test_retrigger();
    test_back_to_back();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
